pc_redirect_ctrl: RTL and testbench

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

---
 rtl/pc_redirect_ctrl_pkg.sv | 30 +++
 rtl/redirect_prio_sel.sv | 35 +++
 rtl/pc_redirect_ctrl.sv | 142 ++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the PC redirect controller:
// FSM states, request priority classes and the pending-request bundle.
package pc_redirect_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [1:0] CLS_BR1  = 2'd0;
  localparam logic [1:0] CLS_BR0  = 2'd1;
  localparam logic [1:0] CLS_TRAP = 2'd2;

  localparam int unsigned FLUSH_CYCLES_DEF = 2;

  typedef struct packed {
    logic        vld;
    logic [1:0]  cls;
    logic [31:0] addr;
  } redir_t;

  function automatic logic [7:0] sat_add8(
    input logic [7:0] a,
    input logic [1:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/redirect_prio_sel.sv
// Fixed-priority pick among trap, way0 and way1 redirect requests.
// Reports the winner and how many of the other requests lose.
module redirect_prio_sel
  import pc_redirect_ctrl_pkg::*;
(
  input  logic        trap_valid_i,
  input  logic [31:0] trap_addr_i,
  input  logic        br0_valid_i,
  input  logic [31:0] br0_addr_i,
  input  logic        br1_valid_i,
  input  logic [31:0] br1_addr_i,
  output redir_t      win_o,
  output logic [1:0]  drop_o
);

  logic [1:0] n_req;

  always_comb begin
    win_o = '0;
    priority case (1'b1)
      trap_valid_i: win_o = '{1'b1, CLS_TRAP, trap_addr_i};
      br0_valid_i:  win_o = '{1'b1, CLS_BR0, br0_addr_i};
      br1_valid_i:  win_o = '{1'b1, CLS_BR1, br1_addr_i};
      default:      win_o = '0;
    endcase
  end

  always_comb begin
    n_req = {1'b0, trap_valid_i}
          + {1'b0, br0_valid_i}
          + {1'b0, br1_valid_i};
    drop_o = (n_req == 2'd0) ? 2'd0 : n_req - 2'd1;
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Arbitrates trap/branch redirects, holds them until both PC units
// are ready, then broadcasts a jump and squashes the wrong path.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trap_valid_i,
  input  logic [31:0] trap_addr_i,
  input  logic        br0_valid_i,
  input  logic [31:0] br0_addr_i,
  input  logic        br1_valid_i,
  input  logic [31:0] br1_addr_i,
  input  logic        pcu0_ready_i,
  input  logic        pcu1_ready_i,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        flush_o,
  output logic        busy_o,
  output logic        misalign_o,
  output logic [7:0]  drop_cnt_o
);

  localparam logic [3:0] FC = 4'(FLUSH_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  redir_t      pend_q, pend_d;
  logic        jump_flag_q, jump_flag_d;
  logic [31:0] jump_addr_q, jump_addr_d;
  logic        flush_q, flush_d;
  logic        misalign_q, misalign_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  redir_t      sel;
  logic [1:0]  sel_drop;
  redir_t      cand;
  logic [1:0]  drops;
  logic        both_ready;

  redirect_prio_sel u_sel (
    .trap_valid_i (trap_valid_i),
    .trap_addr_i  (trap_addr_i),
    .br0_valid_i  (br0_valid_i),
    .br0_addr_i   (br0_addr_i),
    .br1_valid_i  (br1_valid_i),
    .br1_addr_i   (br1_addr_i),
    .win_o        (sel),
    .drop_o       (sel_drop)
  );

  assign both_ready = pcu0_ready_i & pcu1_ready_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    jump_flag_d = 1'b0;
    jump_addr_d = jump_addr_q;
    flush_d     = flush_q;
    misalign_d  = 1'b0;
    cand        = '0;
    drops       = sel_drop;

    unique case (state_q)
      ST_IDLE: cand = sel;
      ST_PEND: begin
        if (sel.vld && (sel.cls > pend_q.cls)) begin
          cand  = sel;
          drops = sel_drop + 2'd1;
        end else begin
          cand  = pend_q;
          drops = sel_drop + {1'b0, sel.vld};
        end
      end
      ST_FLUSH: begin
        // branches seen during a flush are on the wrong path
        cand  = '{trap_valid_i, CLS_TRAP, trap_addr_i};
        drops = {1'b0, br0_valid_i} + {1'b0, br1_valid_i};
      end
      default: state_d = ST_IDLE;
    endcase

    if (cand.vld) begin
      if (both_ready) begin
        jump_flag_d = 1'b1;
        jump_addr_d = {cand.addr[31:2], 2'b00};
        misalign_d  = |cand.addr[1:0];
        flush_d     = 1'b1;
        cnt_d       = FC;
        state_d     = ST_FLUSH;
        pend_d      = '0;
      end else begin
        pend_d  = cand;
        state_d = ST_PEND;
        flush_d = 1'b0;
        cnt_d   = 4'd0;
      end
    end else if (state_q == ST_FLUSH) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q <= 4'd1) begin
        state_d = ST_IDLE;
        flush_d = 1'b0;
        cnt_d   = 4'd0;
      end
    end

    drop_cnt_d = sat_add8(drop_cnt_q, drops);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      pend_q      <= '0;
      jump_flag_q <= 1'b0;
      jump_addr_q <= 32'd0;
      flush_q     <= 1'b0;
      misalign_q  <= 1'b0;
      drop_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      jump_flag_q <= jump_flag_d;
      jump_addr_q <= jump_addr_d;
      flush_q     <= flush_d;
      misalign_q  <= misalign_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign jump_flag_o = jump_flag_q;
  assign jump_addr_o = jump_addr_q;
  assign flush_o     = flush_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign misalign_o  = misalign_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed checks of pc_redirect_ctrl: issue, arbitration, pending,
// flush preemption, misalignment, reset discard and drop saturation.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trap_valid_i;
  logic [31:0] trap_addr_i;
  logic        br0_valid_i;
  logic [31:0] br0_addr_i;
  logic        br1_valid_i;
  logic [31:0] br1_addr_i;
  logic        pcu0_ready_i;
  logic        pcu1_ready_i;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        flush_o;
  logic        busy_o;
  logic        misalign_o;
  logic [7:0]  drop_cnt_o;

  int nchk = 0;
  int nerr = 0;

  pc_redirect_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .trap_valid_i (trap_valid_i),
    .trap_addr_i  (trap_addr_i),
    .br0_valid_i  (br0_valid_i),
    .br0_addr_i   (br0_addr_i),
    .br1_valid_i  (br1_valid_i),
    .br1_addr_i   (br1_addr_i),
    .pcu0_ready_i (pcu0_ready_i),
    .pcu1_ready_i (pcu1_ready_i),
    .jump_flag_o  (jump_flag_o),
    .jump_addr_o  (jump_addr_o),
    .flush_o      (flush_o),
    .busy_o       (busy_o),
    .misalign_o   (misalign_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    trap_valid_i = 1'b0;
    br0_valid_i  = 1'b0;
    br1_valid_i  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b0;
    trap_addr_i  = 32'h0;
    br0_addr_i   = 32'h0;
    br1_addr_i   = 32'h0;
    pcu0_ready_i = 1'b1;
    pcu1_ready_i = 1'b1;
    idle_in();
    #12;
    chk("rst_jf", 32'(jump_flag_o), 32'd0);
    chk("rst_addr", jump_addr_o, 32'h0);
    chk("rst_flush", 32'(flush_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_mis", 32'(misalign_o), 32'd0);
    chk("rst_drop", 32'(drop_cnt_o), 32'd0);
    reset_n = 1'b1;

    // single br0 redirect, flush for two cycles
    br0_valid_i = 1'b1;
    br0_addr_i  = 32'h1000;
    step();
    chk("b0_jf", 32'(jump_flag_o), 32'd1);
    chk("b0_addr", jump_addr_o, 32'h1000);
    chk("b0_flush1", 32'(flush_o), 32'd1);
    chk("b0_busy", 32'(busy_o), 32'd1);
    chk("b0_mis", 32'(misalign_o), 32'd0);
    idle_in();
    step();
    chk("b0_jf2", 32'(jump_flag_o), 32'd0);
    chk("b0_flush2", 32'(flush_o), 32'd1);
    chk("b0_hold", jump_addr_o, 32'h1000);
    step();
    chk("b0_flush3", 32'(flush_o), 32'd0);
    chk("b0_idle", 32'(busy_o), 32'd0);

    // three-way arbitration
    trap_valid_i = 1'b1; trap_addr_i = 32'h80;
    br0_valid_i  = 1'b1; br0_addr_i  = 32'h200;
    br1_valid_i  = 1'b1; br1_addr_i  = 32'h300;
    step();
    chk("arb_jf", 32'(jump_flag_o), 32'd1);
    chk("arb_addr", jump_addr_o, 32'h80);
    chk("arb_drop", 32'(drop_cnt_o), 32'd2);
    idle_in();
    step();
    step();
    chk("arb_idle", 32'(busy_o), 32'd0);

    // pending br1 replaced by br0 while way1 stalls
    do_reset();
    pcu1_ready_i = 1'b0;
    br1_valid_i = 1'b1; br1_addr_i = 32'h400;
    step();
    chk("pd_busy", 32'(busy_o), 32'd1);
    chk("pd_jf", 32'(jump_flag_o), 32'd0);
    chk("pd_flush", 32'(flush_o), 32'd0);
    idle_in();
    br0_valid_i = 1'b1; br0_addr_i = 32'h500;
    step();
    chk("pd_drop", 32'(drop_cnt_o), 32'd1);
    idle_in();
    step();
    chk("pd_jf3", 32'(jump_flag_o), 32'd0);
    pcu1_ready_i = 1'b1;
    step();
    chk("pd_jf4", 32'(jump_flag_o), 32'd1);
    chk("pd_addr", jump_addr_o, 32'h500);
    chk("pd_drop2", 32'(drop_cnt_o), 32'd1);
    step();
    step();

    // trap preempts flush, later br1 is wrong-path
    do_reset();
    br0_valid_i = 1'b1; br0_addr_i = 32'h600;
    step();
    chk("fp_jf1", 32'(jump_flag_o), 32'd1);
    chk("fp_addr1", jump_addr_o, 32'h600);
    idle_in();
    trap_valid_i = 1'b1; trap_addr_i = 32'h800;
    step();
    chk("fp_jf2", 32'(jump_flag_o), 32'd1);
    chk("fp_addr2", jump_addr_o, 32'h800);
    chk("fp_flush2", 32'(flush_o), 32'd1);
    idle_in();
    br1_valid_i = 1'b1; br1_addr_i = 32'h700;
    step();
    chk("fp_jf3", 32'(jump_flag_o), 32'd0);
    chk("fp_flush3", 32'(flush_o), 32'd1);
    chk("fp_addr3", jump_addr_o, 32'h800);
    chk("fp_drop", 32'(drop_cnt_o), 32'd1);
    idle_in();
    step();
    chk("fp_flush4", 32'(flush_o), 32'd0);
    chk("fp_idle", 32'(busy_o), 32'd0);

    // misaligned target
    br0_valid_i = 1'b1; br0_addr_i = 32'h1002;
    step();
    chk("ma_addr", jump_addr_o, 32'h1000);
    chk("ma_mis1", 32'(misalign_o), 32'd1);
    idle_in();
    step();
    chk("ma_mis2", 32'(misalign_o), 32'd0);
    step();

    // equal class dropped in PEND, trap wins on ready cycle
    do_reset();
    pcu0_ready_i = 1'b0;
    br1_valid_i = 1'b1; br1_addr_i = 32'h900;
    step();
    chk("eq_busy", 32'(busy_o), 32'd1);
    br1_addr_i = 32'h904;
    step();
    chk("eq_drop", 32'(drop_cnt_o), 32'd1);
    chk("eq_jf", 32'(jump_flag_o), 32'd0);
    idle_in();
    trap_valid_i = 1'b1; trap_addr_i = 32'hA00;
    pcu0_ready_i = 1'b1;
    step();
    chk("eq_jf2", 32'(jump_flag_o), 32'd1);
    chk("eq_addr", jump_addr_o, 32'hA00);
    chk("eq_drop2", 32'(drop_cnt_o), 32'd2);
    idle_in();
    step();
    step();

    // reset while pending discards the redirect
    do_reset();
    pcu0_ready_i = 1'b0;
    br0_valid_i = 1'b1; br0_addr_i = 32'h1234;
    step();
    chk("rp_busy", 32'(busy_o), 32'd1);
    idle_in();
    reset_n = 1'b0;
    #2;
    chk("rp_async", 32'(busy_o), 32'd0);
    reset_n = 1'b1;
    pcu0_ready_i = 1'b1;
    step();
    chk("rp_jf", 32'(jump_flag_o), 32'd0);
    chk("rp_drop", 32'(drop_cnt_o), 32'd0);
    chk("rp_busy2", 32'(busy_o), 32'd0);

    // 2 + 99*3 = 299 drops saturate at 255
    pcu0_ready_i = 1'b0;
    trap_valid_i = 1'b1; trap_addr_i = 32'h40;
    br0_valid_i  = 1'b1; br0_addr_i  = 32'h44;
    br1_valid_i  = 1'b1; br1_addr_i  = 32'h48;
    step();
    chk("sat_first", 32'(drop_cnt_o), 32'd2);
    for (int i = 0; i < 99; i++) step();
    chk("sat_max", 32'(drop_cnt_o), 32'd255);
    chk("sat_jf", 32'(jump_flag_o), 32'd0);
    step();
    chk("sat_hold", 32'(drop_cnt_o), 32'd255);
    idle_in();
    pcu0_ready_i = 1'b1;
    step();
    chk("sat_issue", jump_addr_o, 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
